// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the RV64 core datapath.
// Steps each instruction through FETCH -> IWAIT -> DECODE -> [MREQ -> MWAIT] -> WB.
// It issues the datapath write-enables (ir_we, rf_we, pc_we), raises sticky
// halt/trap flags in STOP, and keeps the cycle and retired-instruction counters.
// All outputs are forced low while rst is held low, so an abandoned access
// cannot produce stray requests or enables.
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_rf_wen,
    input  logic             dec_is_ebreak,
    input  logic             dec_illegal,
    output logic             dmem_req_valid,
    output logic             dmem_req_wen,
    input  logic             dmem_req_ready,
    input  logic             dmem_resp_valid,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic             trap,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_IWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_MREQ   = 3'd4,
        S_MWAIT  = 3'd5,
        S_WB     = 3'd6,
        S_STOP   = 3'd7
    } state_t;

    // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             halt_q, halt_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic             st_q, st_d;
    logic             rfw_q, rfw_d;
    logic             tmo_expire;
    logic             in_wait;

    // The cycle now being spent in a handshake state is the TIMEOUT-th one.
    assign tmo_expire = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign in_wait    = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                        (state_q == S_MREQ)  || (state_q == S_MWAIT);

    // Next-state, sticky flags, decode latches, counters and timeout count.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        trap_d  = trap_q;
        inst_d  = inst_q;
        cyc_d   = cyc_q;
        st_d    = st_q;
        rfw_d   = rfw_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_d = S_IWAIT;
                end else if (tmo_expire) begin
                    state_d = S_STOP;
                    trap_d  = 1'b1;
                end
            end
            S_IWAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_DECODE;
                end else if (tmo_expire) begin
                    state_d = S_STOP;
                    trap_d  = 1'b1;
                end
            end
            S_DECODE: begin
                st_d  = dec_is_store;
                rfw_d = dec_rf_wen;
                if (dec_illegal || (dec_is_load && dec_is_store)) begin
                    state_d = S_STOP;
                    trap_d  = 1'b1;
                end else if (dec_is_ebreak) begin
                    state_d = S_STOP;
                    halt_d  = 1'b1;
                    inst_d  = inst_q + CNT_W'(1);
                end else if (dec_is_load || dec_is_store) begin
                    state_d = S_MREQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MREQ: begin
                if (dmem_req_ready) begin
                    state_d = S_MWAIT;
                end else if (tmo_expire) begin
                    state_d = S_STOP;
                    trap_d  = 1'b1;
                end
            end
            S_MWAIT: begin
                if (dmem_resp_valid) begin
                    state_d = S_WB;
                end else if (tmo_expire) begin
                    state_d = S_STOP;
                    trap_d  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                inst_d  = inst_q + CNT_W'(1);
            end
            default: state_d = S_STOP;
        endcase
        if ((state_q != S_IDLE) && (state_q != S_STOP)) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
        if (in_wait && (state_d == state_q)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            halt_q  <= 1'b0;
            trap_q  <= 1'b0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            halt_q  <= halt_d;
            trap_q  <= trap_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    // Decode flags captured in DECODE; only consumed in later states, so no reset.
    always_ff @(posedge clk) begin
        st_q  <= st_d;
        rfw_q <= rfw_d;
    end

    // Outputs decoded from registered state; ir_we follows the response in IWAIT.
    always_comb begin
        imem_req_valid = rst && (state_q == S_FETCH);
        ir_we          = rst && (state_q == S_IWAIT) && imem_resp_valid;
        dmem_req_valid = rst && (state_q == S_MREQ);
        dmem_req_wen   = rst && (state_q == S_MREQ) && st_q;
        pc_we          = rst && (state_q == S_WB);
        rf_we          = rst && (state_q == S_WB) && rfw_q && !st_q;
        halt           = rst && (state_q == S_STOP) && halt_q;
        trap           = rst && (state_q == S_STOP) && trap_q;
        state_o        = rst ? state_q : S_IDLE;
        cycle_cnt      = rst ? cyc_q : '0;
        instret_cnt    = rst ? inst_q : '0;
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a timeline model turns a list of instructions
// (kind plus per-handshake wait lengths) into per-cycle input vectors and the
// outputs the sequencer must show, and one process compares every cycle.
module tb_core_seq_ctrl;
    localparam int TMO = 4;
    localparam int K_ADDI = 0, K_LOAD = 1, K_STORE = 2, K_EBRK = 3, K_ILL = 4, K_LDST = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_rf_wen = 1'b0;
    logic        dec_is_ebreak = 1'b0, dec_illegal = 1'b0;
    logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
    logic        imem_req_valid, dmem_req_valid, dmem_req_wen;
    logic        ir_we, rf_we, pc_we, halt, trap;
    logic [2:0]  state_o;
    logic [63:0] cycle_cnt, instret_cnt;

    core_seq_ctrl #(.TIMEOUT(TMO), .CNT_W(64)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rf_wen(dec_rf_wen),
        .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
        .dmem_req_valid(dmem_req_valid), .dmem_req_wen(dmem_req_wen),
        .dmem_req_ready(dmem_req_ready), .dmem_resp_valid(dmem_resp_valid),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .trap(trap),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, ireq_rdy, iresp_v, dreq_rdy, dresp_v, ld, st, rfw, ebrk, ill;
        logic        e_ireq_v, e_dreq_v, e_dwen, e_ir_we, e_rf_we, e_pc_we, e_halt, e_trap;
        logic [2:0]  e_state;
        logic [63:0] e_cyc, e_inst;
    } vec_t;

    vec_t        vq[$];
    logic [63:0] mcyc = 0, minst = 0;
    logic        mhalt = 0, mtrap = 0;
    int          nvec = 0, nerr = 0, cur = 0;
    bit          run = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    // Every input asserted: handshakes and decode flags that must be ignored.
    function automatic vec_t noisy();
        vec_t v;
        v = '0;
        v.rst = 1; v.ireq_rdy = 1; v.iresp_v = 1; v.dreq_rdy = 1; v.dresp_v = 1;
        v.ld = 1; v.st = 1; v.rfw = 1; v.ebrk = 1; v.ill = 1;
        return v;
    endfunction

    task automatic emit(input vec_t v, input logic [2:0] s);
        v.e_state = s;
        v.e_cyc   = mcyc;
        v.e_inst  = minst;
        v.e_halt  = (s == 3'd7) && mhalt;
        v.e_trap  = (s == 3'd7) && mtrap;
        vq.push_back(v);
        if (s != 3'd0 && s != 3'd7) mcyc++;
    endtask

    task automatic do_reset(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = noisy();
            v.rst = 0;
            vq.push_back(v);
        end
        mcyc = 0; minst = 0; mhalt = 0; mtrap = 0;
        emit(noisy(), 3'd0);
    endtask

    // A handshake state whose exit fires on cycle dly+1, unless the limit hits first.
    task automatic hs_phase(input logic [2:0] s, input int dly, input logic st_lat, output bit to);
        vec_t v;
        int   n;
        bit   fire;
        n  = (TMO != 0 && dly + 1 > TMO) ? TMO : dly + 1;
        to = (n != dly + 1);
        for (int i = 0; i < n; i++) begin
            v = noisy();
            fire = (i == dly);
            case (s)
                3'd1: begin v.ireq_rdy = fire; v.e_ireq_v = 1; end
                3'd2: begin v.iresp_v = fire; v.e_ir_we = fire; end
                3'd4: begin v.dreq_rdy = fire; v.e_dreq_v = 1; v.e_dwen = st_lat; end
                default: v.dresp_v = fire;
            endcase
            emit(v, s);
        end
        if (to) mtrap = 1;
    endtask

    task automatic instr(input int kind, input int fa, input int ib, input int dc, input int dd);
        bit   to, ld, st, rfw, eb, il;
        vec_t v;
        hs_phase(3'd1, fa, 1'b0, to); if (to) return;
        hs_phase(3'd2, ib, 1'b0, to); if (to) return;
        ld  = (kind == K_LOAD) || (kind == K_LDST);
        st  = (kind == K_STORE) || (kind == K_LDST);
        rfw = (kind == K_ADDI) || (kind == K_LOAD) || (kind == K_STORE);
        eb  = (kind == K_EBRK);
        il  = (kind == K_ILL);
        v = noisy();
        v.ld = ld; v.st = st; v.rfw = rfw; v.ebrk = eb; v.ill = il;
        emit(v, 3'd3);
        if (il || (ld && st)) begin mtrap = 1; return; end
        if (eb) begin mhalt = 1; minst++; return; end
        if (ld || st) begin
            hs_phase(3'd4, dc, st, to); if (to) return;
            hs_phase(3'd5, dd, st, to); if (to) return;
        end
        v = noisy();
        v.e_pc_we = 1;
        v.e_rf_we = rfw && !st;
        emit(v, 3'd6);
        minst++;
    endtask

    task automatic stop_cycles(input int n);
        for (int i = 0; i < n; i++) emit(noisy(), 3'd7);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        imem_req_ready = v.ireq_rdy; imem_resp_valid = v.iresp_v;
        dmem_req_ready = v.dreq_rdy; dmem_resp_valid = v.dresp_v;
        dec_is_load = v.ld; dec_is_store = v.st; dec_rf_wen = v.rfw;
        dec_is_ebreak = v.ebrk; dec_illegal = v.ill;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            vec_t e;
            e = vq[cur];
            nvec++;
            check("state_o", cur, 64'(state_o), 64'(e.e_state));
            check("imem_req_valid", cur, 64'(imem_req_valid), 64'(e.e_ireq_v));
            check("ir_we", cur, 64'(ir_we), 64'(e.e_ir_we));
            check("dmem_req_valid", cur, 64'(dmem_req_valid), 64'(e.e_dreq_v));
            check("dmem_req_wen", cur, 64'(dmem_req_wen), 64'(e.e_dwen));
            check("pc_we", cur, 64'(pc_we), 64'(e.e_pc_we));
            check("rf_we", cur, 64'(rf_we), 64'(e.e_rf_we));
            check("halt", cur, 64'(halt), 64'(e.e_halt));
            check("trap", cur, 64'(trap), 64'(e.e_trap));
            check("cycle_cnt", cur, cycle_cnt, e.e_cyc);
            check("instret_cnt", cur, instret_cnt, e.e_inst);
        end
    end

    initial begin
        int          base;
        logic [63:0] c0;
        bit          to;

        // Three back-to-back addi with zero-wait memory.
        do_reset(2);
        base = vq.size() - 1;
        repeat (3) instr(K_ADDI, 0, 0, 0, 0);
        check("pin_addi_cyc", 0, mcyc, 64'd12);
        check("pin_addi_inst", 0, minst, 64'd3);
        check("pin_pc_we_4", 0, 64'(vq[base + 4].e_pc_we), 64'd1);
        check("pin_pc_we_8", 0, 64'(vq[base + 8].e_pc_we), 64'd1);
        check("pin_pc_we_12", 0, 64'(vq[base + 12].e_pc_we), 64'd1);
        check("pin_rf_we_12", 0, 64'(vq[base + 12].e_rf_we), 64'd1);
        // Reset while waiting for the instruction word.
        hs_phase(3'd1, 2, 1'b0, to);
        do_reset(1);

        // Slow load, then store with rf_wen set, then reset in MWAIT.
        c0 = mcyc;
        instr(K_LOAD, 2, 0, 0, 3);
        check("pin_load_len", 0, mcyc - c0, 64'd11);
        c0 = mcyc;
        instr(K_STORE, 0, 0, 0, 0);
        check("pin_store_len", 0, mcyc - c0, 64'd6);
        check("pin_store_inst", 0, minst, 64'd2);
        instr(K_LOAD, 0, 0, 0, 2);
        void'(vq.pop_back());
        void'(vq.pop_back());
        do_reset(1);
        instr(K_ADDI, 0, 0, 0, 0);
        instr(K_ILL, 0, 0, 0, 0);
        check("pin_ill_inst", 0, minst, 64'd1);
        stop_cycles(5);

        // ebreak after two addi.
        do_reset(2);
        instr(K_ADDI, 0, 0, 0, 0);
        instr(K_ADDI, 0, 0, 0, 0);
        instr(K_EBRK, 0, 0, 0, 0);
        check("pin_ebrk_cyc", 0, mcyc, 64'd11);
        check("pin_ebrk_inst", 0, minst, 64'd3);
        stop_cycles(20);

        // Timeout in IWAIT.
        do_reset(1);
        instr(K_ADDI, 0, 10, 0, 0);
        stop_cycles(3);

        // Response on the last allowed IWAIT cycle, then a load timing out in MWAIT.
        do_reset(1);
        instr(K_ADDI, 0, 3, 0, 0);
        instr(K_LOAD, 1, 0, 2, 9);
        stop_cycles(3);

        // Load and store both decoded.
        do_reset(1);
        instr(K_ADDI, 0, 0, 0, 0);
        instr(K_LDST, 0, 0, 0, 0);
        stop_cycles(3);

        // Store with slow acceptance, then timeout in FETCH.
        do_reset(1);
        instr(K_STORE, 0, 0, 3, 0);
        instr(K_ADDI, 7, 0, 0, 0);
        stop_cycles(3);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vq[i]);
            cur = i;
            run = 1;
        end
        @(posedge clk);
        run = 0;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64 core datapath (PC register, decoder, register file, adder).
- Steps each instruction through fetch, decode, memory and writeback.
- Talks to instruction and data memory over valid/ready handshakes.
- Issues the write-enables that the datapath applies on the next clock edge: PC, instruction register, register file.
- Reports halt on ebreak, traps on illegal or timed-out accesses, and keeps cycle and retired-instruction counters.

Parameters:
- TIMEOUT, default 255: max cycles waited in any handshake state before trapping; 0 disables the timeout.
- CNT_W, default 64: width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request at current PC
- imem_req_ready  in  1  imem accepts request
- imem_resp_valid  in  1  instruction word valid this cycle
- dec_is_load  in  1  decoded load (valid while IR held)
- dec_is_store  in  1  decoded store
- dec_rf_wen  in  1  instruction writes rd
- dec_is_ebreak  in  1  decoded ebreak
- dec_illegal  in  1  undecodable instruction
- dmem_req_valid  out  1  data access request
- dmem_req_wen  out  1  1 = store, 0 = load; meaningful only with dmem_req_valid
- dmem_req_ready  in  1  dmem accepts request
- dmem_resp_valid  in  1  data access complete
- ir_we  out  1  latch instruction into IR
- rf_we  out  1  register file write
- pc_we  out  1  load next PC
- halt  out  1  ebreak reached (sticky)
- trap  out  1  illegal/timeout (sticky)
- state_o  out  3  current state, for debug
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset is synchronous and active-low: when rst==0 at a rising edge, next state is IDLE, the timeout counter and both counters clear, and halt/trap clear. All outputs are 0 during and right after reset.
- State encoding: IDLE=0, FETCH=1, IWAIT=2, DECODE=3, MREQ=4, MWAIT=5, WB=6, STOP=7.
- Only STOP drives halt or trap.
- IDLE: go to FETCH next cycle unconditionally.
- FETCH: imem_req_valid=1. When imem_req_ready=1 in the same cycle, go to IWAIT.
- IWAIT: when imem_resp_valid=1, ir_we=1 (combinational, same cycle) and go to DECODE.
- DECODE: one cycle, no enables asserted. Decode flags are sampled and latched internally. Priority, highest first:
  - dec_illegal, or dec_is_load and dec_is_store both set -> STOP, trap=1.
  - dec_is_ebreak -> STOP, halt=1, instret_cnt+1.
  - load or store -> MREQ.
  - otherwise -> WB.
- MREQ: dmem_req_valid=1 and dmem_req_wen=latched store. When dmem_req_ready=1, go to MWAIT.
- MWAIT: when dmem_resp_valid=1, go to WB.
- WB: one cycle.
  - pc_we=1.
  - rf_we = latched rf_wen and not latched store.
  - instret_cnt+1.
  - Next state FETCH.
- STOP: absorbing until reset. No requests, no enables. halt/trap held. Counters frozen.
- Timeout:
  - One counter, cleared on every state change and incremented each cycle spent in FETCH, IWAIT, MREQ or MWAIT.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without the exit condition firing -> STOP with trap=1.
  - If the exit condition occurs in the same cycle the count hits TIMEOUT, the handshake wins.
- cycle_cnt increments every cycle in states other than IDLE and STOP. Both counters wrap modulo 2^CNT_W.
- The minimum instruction is 4 cycles with zero-wait memory (FETCH, IWAIT, DECODE, WB). Loads and stores take 6.
- A request, once valid, stays asserted until accepted. Address and wen stay stable while waiting.
- Responses arriving outside IWAIT or MWAIT are ignored.
- Reset asserted mid-transaction abandons the access. No enable pulses follow.

Test Plan:
- Reset, then an always-ready imem returning addi (rf_wen=1) ×3 -> pc_we pulses at cycles 4, 8 and 12 after leaving IDLE; instret_cnt=3; cycle_cnt=12; rf_we coincides with each pc_we.
- Load with imem_req_ready delayed 2 cycles and dmem_resp_valid delayed 3 cycles -> imem_req_valid held 3 cycles; dmem_req_wen=0; rf_we=1 in WB; instruction takes 11 cycles.
- Store (dec_rf_wen=1 deliberately) -> dmem_req_wen=1; rf_we=0 in WB; pc_we=1; instret +1.
- ebreak after 2 addi -> halt=1 sticky; instret_cnt=3; cycle_cnt frozen at 11; no further imem_req_valid over 20 cycles.
- TIMEOUT=4, imem_resp_valid never asserted -> trap=1 after 4 IWAIT cycles. Separately, resp arriving on the 4th IWAIT cycle -> no trap, normal DECODE.
- rst driven low during MWAIT -> next cycle state_o=0 and all outputs 0; restart fetches normally. A dec_illegal instruction -> trap=1 and instret unchanged.
